// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared CPU constants and types for the fetch stage
//
// Purpose: default reset PC and NOP encoding, IF state encoding, redirect
// target select codes and small helpers used by stage_if and if_id_reg.
// Ports: none (package).
package stage_if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } if_state_t;

  // Which source supplies the redirect target this cycle.
  typedef enum logic [1:0] {
    RSEL_NONE   = 2'd0,
    RSEL_JUMP   = 2'd1,
    RSEL_BRANCH = 2'd2,
    RSEL_PEND   = 2'd3
  } redir_sel_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // A taken branch comes from the older instruction (EX), so it beats a
  // jump from ID; a live request beats a remembered one.
  function automatic redir_sel_t redir_select(input logic br_taken,
                                              input logic jump,
                                              input logic pend_v);
    if (br_taken)    return RSEL_BRANCH;
    else if (jump)   return RSEL_JUMP;
    else if (pend_v) return RSEL_PEND;
    else             return RSEL_NONE;
  endfunction

endpackage

// File: rtl/stage_if_if.sv
// rtl/stage_if_if.sv - instruction memory request/ready bus
//
// Purpose: groups the fetch-side instruction memory handshake.
// Signals:
//   imem_req   - request valid (driven by the fetch stage)
//   imem_addr  - fetch address, stable while req=1 and ready=0
//   imem_ready - memory completes the request this cycle
//   imem_rdata - instruction word, valid when req and ready are both high
// Modports: master (fetch stage), slave (memory).
interface stage_if_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/stage_if_if_id_reg.sv
// rtl/stage_if_if_id_reg.sv - IF/ID pipeline register
//
// Purpose: pipeline register with reset > flush > stall > load > bubble
// priority. Flush turns the slot into a bubble but keeps the PC fields.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush, stall, load  - update controls
//   pc_in, pc4_in, inst_in - fields captured on load
//   pc_out, pc4_out, inst_out, valid_out - registered fields
module if_id_reg
  import stage_if_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc4_in,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out    <= 32'd0;
      pc4_out   <= 32'd0;
      inst_out  <= NOP_INST;
      valid_out <= 1'b0;
    end else if (flush) begin
      inst_out  <= NOP_INST;
      valid_out <= 1'b0;
    end else if (stall) begin
      pc_out    <= pc_out;
      pc4_out   <= pc4_out;
      inst_out  <= inst_out;
      valid_out <= valid_out;
    end else if (load) begin
      pc_out    <= pc_in;
      pc4_out   <= pc4_in;
      inst_out  <= inst_in;
      valid_out <= 1'b1;
    end else begin
      inst_out  <= NOP_INST;
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction fetch stage
//
// Purpose: holds the PC, fetches over a req/ready handshake, parks a word
// completed during a stall, remembers redirects that arrive while a request
// is outstanding, and loads the IF/ID register.
// Ports:
//   Clk, Reset          - clock, synchronous active-high reset
//   Stall, Flush        - hazard hold / squash of IF/ID
//   Jump, Jtarg         - jump redirect from ID
//   Br_Taken, Btarg     - taken-branch redirect from EX
//   imem                - instruction memory bus (master side)
//   IFout_PC, IFout_PC4, IFout_Inst, IFout_Valid - IF/ID outputs
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             Jump,
  input  logic [31:0]      Jtarg,
  input  logic             Br_Taken,
  input  logic [31:0]      Btarg,
  stage_if_if.master       imem,
  output logic [31:0]      IFout_PC,
  output logic [31:0]      IFout_PC4,
  output logic [31:0]      IFout_Inst,
  output logic             IFout_Valid
);

  if_state_t   state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc4;
  logic        pend_v, pend_v_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic        done, redir, eff_redir, load;
  logic [31:0] eff_tgt, load_inst;
  redir_sel_t  rsel;

  // Request drops during reset so an outstanding access is simply abandoned.
  assign imem.imem_req  = (state == S_FETCH) && !Reset;
  assign imem.imem_addr = pc;

  assign done      = imem.imem_req & imem.imem_ready;
  assign redir     = Br_Taken | Jump;
  assign eff_redir = redir | pend_v;
  assign pc4       = pc_plus4(pc);
  assign rsel      = redir_select(Br_Taken, Jump, pend_v);

  always_comb begin
    eff_tgt = pc;
    case (rsel)
      RSEL_BRANCH: eff_tgt = Btarg;
      RSEL_JUMP:   eff_tgt = Jtarg;
      RSEL_PEND:   eff_tgt = pend_tgt;
      default:     eff_tgt = pc;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_v_nxt   = pend_v;
    pend_tgt_nxt = pend_tgt;
    hold_buf_nxt = hold_buf;
    load         = 1'b0;
    load_inst    = imem.imem_rdata;
    case (state)
      S_FETCH: begin
        if (done) begin
          if (eff_redir) begin
            // Word belongs to the wrong path; go straight to the target.
            pc_nxt     = eff_tgt;
            pend_v_nxt = 1'b0;
          end else if (Flush) begin
            // Word is squashed; PC stays so the same address is refetched.
            pc_nxt = pc;
          end else if (!Stall) begin
            load   = 1'b1;
            pc_nxt = pc4;
          end else begin
            // Memory cannot be asked to repeat, so park the word.
            hold_buf_nxt = imem.imem_rdata;
            state_nxt    = S_HOLD;
          end
        end else if (redir) begin
          // Address must stay stable until ready; remember the target.
          pend_v_nxt   = 1'b1;
          pend_tgt_nxt = eff_tgt;
        end
      end
      S_HOLD: begin
        load_inst = hold_buf;
        if (eff_redir) begin
          pc_nxt     = eff_tgt;
          pend_v_nxt = 1'b0;
          state_nxt  = S_FETCH;
        end else if (Flush) begin
          state_nxt = S_FETCH;
        end else if (!Stall) begin
          load      = 1'b1;
          pc_nxt    = pc4;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      pend_v   <= 1'b0;
      pend_tgt <= RESET_PC;
      hold_buf <= NOP_INST;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend_v   <= pend_v_nxt;
      pend_tgt <= pend_tgt_nxt;
      hold_buf <= hold_buf_nxt;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk       (Clk),
    .rst       (Reset),
    .flush     (Flush),
    .stall     (Stall),
    .load      (load),
    .pc_in     (pc),
    .pc4_in    (pc4),
    .inst_in   (load_inst),
    .pc_out    (IFout_PC),
    .pc4_out   (IFout_PC4),
    .inst_out  (IFout_Inst),
    .valid_out (IFout_Valid)
  );

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - self-checking bench for stage_if
module tb_stage_if;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, Jump, Br_Taken;
  logic [31:0] Jtarg, Btarg;
  logic [31:0] IFout_PC, IFout_PC4, IFout_Inst;
  logic        IFout_Valid;

  stage_if_if imem_bus ();

  stage_if #(
    .RESET_PC (RPC),
    .NOP_INST (NOP)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Stall       (Stall),
    .Flush       (Flush),
    .Jump        (Jump),
    .Jtarg       (Jtarg),
    .Br_Taken    (Br_Taken),
    .Btarg       (Btarg),
    .imem        (imem_bus),
    .IFout_PC    (IFout_PC),
    .IFout_PC4   (IFout_PC4),
    .IFout_Inst  (IFout_Inst),
    .IFout_Valid (IFout_Valid)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: fetcher viewed as "a word is available" (fresh from
  // memory or parked earlier) plus an optional remembered redirect target.
  logic [31:0] m_pc = RPC;
  logic [31:0] m_parked_word = 32'd0;
  bit          m_parked = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_tgt = 32'd0;
  logic [31:0] m_out_pc = 32'd0, m_out_pc4 = 32'd0, m_out_inst = NOP;
  bit          m_out_valid = 1'b0;

  task automatic model_step(input bit rst, input bit st, input bit fl, input bit jp,
                            input logic [31:0] jt, input bit br, input logic [31:0] bt,
                            input bit rdy, input logic [31:0] rd);
    bit          avail, have_redir, take;
    logic [31:0] tgt, word;
    if (rst) begin
      m_pc = RPC; m_parked = 0; m_pend = 0;
      m_out_pc = 0; m_out_pc4 = 0; m_out_inst = NOP; m_out_valid = 0;
      return;
    end
    avail      = m_parked || rdy;
    word       = m_parked ? m_parked_word : rd;
    have_redir = br || jp || m_pend;
    tgt        = br ? bt : (jp ? jt : m_pend_tgt);
    take       = 0;
    if (avail) begin
      if (have_redir) begin
        m_pc = tgt; m_pend = 0; m_parked = 0;
      end else if (fl) begin
        m_parked = 0;
      end else if (!st) begin
        take = 1; m_parked = 0;
      end else if (!m_parked) begin
        m_parked = 1; m_parked_word = rd;
      end
    end else if (br || jp) begin
      m_pend = 1; m_pend_tgt = tgt;
    end
    if (fl) begin
      m_out_inst = NOP; m_out_valid = 0;
    end else if (st) begin
      // IF/ID keeps its contents
    end else if (take) begin
      m_out_pc = m_pc; m_out_pc4 = m_pc + 32'd4; m_out_inst = word; m_out_valid = 1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_out_inst = NOP; m_out_valid = 0;
    end
  endtask

  // One clock: drive inputs, check combinational fetch outputs, advance,
  // then check the registered IF/ID outputs.
  task automatic cyc(input bit rst, input bit st, input bit fl, input bit jp,
                     input logic [31:0] jt, input bit br, input logic [31:0] bt, input bit rdy);
    logic [31:0] rd;
    bit          exp_req;
    rd = $urandom;
    Reset = rst; Stall = st; Flush = fl; Jump = jp; Jtarg = jt;
    Br_Taken = br; Btarg = bt;
    imem_bus.imem_ready = rdy; imem_bus.imem_rdata = rd;
    #1;
    exp_req = !rst && !m_parked;
    check("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, exp_req});
    if (exp_req) check("imem_addr", imem_bus.imem_addr, m_pc);
    model_step(rst, st, fl, jp, jt, br, bt, rdy, rd);
    @(posedge Clk);
    #1;
    check("IFout_PC", IFout_PC, m_out_pc);
    check("IFout_PC4", IFout_PC4, m_out_pc4);
    check("IFout_Inst", IFout_Inst, m_out_inst);
    check("IFout_Valid", {31'd0, IFout_Valid}, {31'd0, m_out_valid});
  endtask

  task automatic fetch(input bit rdy);
    cyc(0, 0, 0, 0, 32'd0, 0, 32'd0, rdy);
  endtask

  function automatic logic [31:0] rand_tgt();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF8;
    return $urandom & 32'h0000_03FC;
  endfunction

  initial begin
    Reset = 1; Stall = 0; Flush = 0; Jump = 0; Br_Taken = 0;
    Jtarg = 0; Btarg = 0;
    imem_bus.imem_ready = 0; imem_bus.imem_rdata = 0;
    @(posedge Clk);
    #1;

    // Reset state and zero-wait streaming.
    cyc(1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    check("rst_valid", {31'd0, IFout_Valid}, 32'd0);
    check("rst_inst", IFout_Inst, NOP);
    check("rst_pc", IFout_PC, 32'd0);
    fetch(1);
    check("zw_pc0", IFout_PC, 32'h0);
    check("zw_addr4", imem_bus.imem_addr, 32'h4);
    fetch(1);
    fetch(1);
    check("zw_pc8", IFout_PC, 32'h8);
    check("zw_pc4_c", IFout_PC4, 32'hC);
    fetch(1);
    check("zw_addr10", imem_bus.imem_addr, 32'h10);

    // Three-cycle latency at PC=8.
    cyc(1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    fetch(1);
    fetch(1);
    fetch(0);
    fetch(0);
    check("lat_addr_held", imem_bus.imem_addr, 32'h8);
    check("lat_wait_valid", {31'd0, IFout_Valid}, 32'd0);
    fetch(1);
    check("lat_pc8", IFout_PC, 32'h8);
    check("lat_valid", {31'd0, IFout_Valid}, 32'd1);

    // Stall as the word at 0x10 completes.
    fetch(1);
    cyc(0, 1, 0, 0, 32'd0, 0, 32'd0, 1);
    check("stall_req0", {31'd0, imem_bus.imem_req}, 32'd0);
    check("stall_hold_pc", IFout_PC, 32'hC);
    cyc(0, 1, 0, 0, 32'd0, 0, 32'd0, 0);
    check("stall_hold_pc2", IFout_PC, 32'hC);
    fetch(0);
    check("stall_rel_pc", IFout_PC, 32'h10);
    check("stall_next_addr", imem_bus.imem_addr, 32'h14);

    // Jump while 0x20 is outstanding.
    fetch(1);
    fetch(1);
    fetch(1);
    cyc(0, 0, 0, 1, 32'h40, 0, 32'd0, 0);
    fetch(0);
    check("jmp_addr_held", imem_bus.imem_addr, 32'h20);
    fetch(1);
    check("jmp_discard", {31'd0, IFout_Valid}, 32'd0);
    check("jmp_addr", imem_bus.imem_addr, 32'h40);

    // Branch and jump together with flush: branch wins.
    cyc(0, 0, 1, 1, 32'h40, 1, 32'h80, 1);
    check("brj_valid", {31'd0, IFout_Valid}, 32'd0);
    check("brj_addr", imem_bus.imem_addr, 32'h80);

    // Reset during an outstanding request at 0x30.
    fetch(1);
    cyc(0, 0, 0, 1, 32'h30, 0, 32'd0, 1);
    fetch(0);
    check("rmr_addr", imem_bus.imem_addr, 32'h30);
    cyc(1, 0, 0, 0, 32'd0, 0, 32'd0, 0);
    check("rmr_valid", {31'd0, IFout_Valid}, 32'd0);
    check("rmr_inst", IFout_Inst, NOP);
    fetch(1);
    check("rmr_resume_pc", IFout_PC, RPC);

    // PC+4 wrap at the top of the address space.
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'd0, 1);
    fetch(1);
    check("wrap_pc4", IFout_PC4, 32'h0);
    check("wrap_addr", imem_bus.imem_addr, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0, rand_tgt(),
          $urandom_range(0, 7) == 0, rand_tgt(),
          $urandom_range(0, 1) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
